// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: widths, FSM states, S-box, round constants
// and the GF(2^8) helpers used by the round datapath and key expansion.
package aes_pkg;

    localparam int BLOCK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    // Indexed directly by the 1-based round number; unused slots are zero.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so the slice offset is (255-b)*8 = {~b, 000}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One combinational AES-128 key-expansion step: previous round key plus
// rcon in, next round key out.
import aes_pkg::*;

module aes_key_step (
    input  logic [BLOCK_W-1:0] key,
    input  logic [7:0]         rcon,
    output logic [BLOCK_W-1:0] next_key
);

    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

    assign w0 = key[127:96];
    assign w1 = key[95:64];
    assign w2 = key[63:32];
    assign w3 = key[31:0];

    // RotWord then SubWord on the last word, rcon folded into the top byte.
    assign t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_iter_cipher.sv
// Iterative AES-128 encryptor: one round per cycle, on-the-fly key schedule,
// valid/ready on both sides. AES_LAST_KEY_OUT_EN adds the last_key output.
import aes_pkg::*;

module aes_iter_cipher #(
    parameter int NR = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] datain,
    input  logic [BLOCK_W-1:0] key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] dataout,
`ifdef AES_LAST_KEY_OUT_EN
    output logic [BLOCK_W-1:0] last_key,
`endif
    output logic               busy
);

    localparam logic [3:0] NR_L = 4'(NR);

    fsm_t               state, state_next;
    logic [BLOCK_W-1:0] st_reg, rk_reg, next_key;
    logic [BLOCK_W-1:0] sb, sr, mc, round_out;
    logic [3:0]         rnd;
    logic               last_round, accept;

    aes_key_step u_key_step (
        .key      (rk_reg),
        .rcon     (RCON[rnd]),
        .next_key (next_key)
    );

    // Byte i of the block lives at bits [127-8i -: 8]; column c is bytes 4c..4c+3.
    always_comb begin
        sb = '0;
        sr = '0;
        mc = '0;
        for (int i = 0; i < 16; i++)
            sb[127-8*i -: 8] = sbox(st_reg[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
        for (int c = 0; c < 4; c++)
            mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
    end

    assign last_round = (rnd == NR_L);
    assign round_out  = (last_round ? sr : mc) ^ next_key;

    // in_ready looks through to out_ready so a finished block can be
    // replaced on the same edge it is delivered.
    assign in_ready  = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_RUN);
    assign dataout   = st_reg;
`ifdef AES_LAST_KEY_OUT_EN
    assign last_key  = rk_reg;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_RUN;
            ST_RUN:  if (last_round) state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = in_valid ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            st_reg <= '0;
            rk_reg <= '0;
            rnd    <= 4'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                st_reg <= datain ^ key;
                rk_reg <= key;
                rnd    <= 4'd1;
            end else if (state == ST_RUN) begin
                st_reg <= round_out;
                rk_reg <= next_key;
                // Parks at NR so the last round key stays selectable while DONE.
                if (!last_round) rnd <= rnd + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_aes_iter_cipher.sv
// Bench for aes_iter_cipher: an NR=10 and an NR=1 instance, each checked
// every cycle against a byte-level AES model with a due-cycle queue.
module tb_aes_iter_cipher;

    localparam logic [127:0] APPB_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] APPB_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] APPB_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_LK    = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst [2];
    logic         iv [2], ir [2], ov [2], ordy [2], bsy [2];
    logic [127:0] din [2], kin [2], dout [2];
`ifdef AES_LAST_KEY_OUT_EN
    logic [127:0] lk [2];
`endif

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int nr_of [2] = '{10, 1};

    aes_iter_cipher #(.NR(10)) dut10 (
        .clk(clk), .rst(rst[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .datain(din[0]), .key(kin[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .dataout(dout[0]),
`ifdef AES_LAST_KEY_OUT_EN
        .last_key(lk[0]),
`endif
        .busy(bsy[0])
    );

    aes_iter_cipher #(.NR(1)) dut1 (
        .clk(clk), .rst(rst[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .datain(din[1]), .key(kin[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .dataout(dout[1]),
`ifdef AES_LAST_KEY_OUT_EN
        .last_key(lk[1]),
`endif
        .busy(bsy[1])
    );

    // ---------------- behavioural AES model ----------------
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic void aes_model(input logic [127:0] pt, input logic [127:0] key_in,
                                      input int nr, output logic [127:0] ct,
                                      output logic [127:0] lastk);
        logic [7:0] s [16], k [16], t [16], tw [4], a [4];
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            s[i] = pt[127-8*i -: 8];
            k[i] = key_in[127-8*i -: 8];
            s[i] = s[i] ^ k[i];
        end
        for (int r = 1; r <= nr; r++) begin
            tw[0] = sbox_m[k[13]] ^ rc;
            tw[1] = sbox_m[k[14]];
            tw[2] = sbox_m[k[15]];
            tw[3] = sbox_m[k[12]];
            rc = gmul(rc, 8'h02);
            for (int i = 0; i < 4; i++) k[i] = k[i] ^ tw[i];
            for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
            for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    t[4*c+rr] = s[4*((c+rr)%4)+rr];
            s = t;
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
                    for (int j = 0; j < 4; j++)
                        s[4*c+j] = gmul(8'h02, a[j]) ^ gmul(8'h03, a[(j+1)%4]) ^ a[(j+2)%4] ^ a[(j+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) begin
            ct[127-8*i -: 8] = s[i];
            lastk[127-8*i -: 8] = k[i];
        end
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    logic [127:0] exp_q [2][$];
    logic [127:0] lk_q [2][$];
    int           due_q [2][$];
    int           n_acc [2] = '{0, 0};
    int           n_dlv [2] = '{0, 0};
    int           acc_cyc [2], dlv_cyc [2];
    logic [127:0] dlv_data [2];
    logic         e_ov, e_ir;
    logic [127:0] m_ct, m_lk;

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                exp_q[d].delete();
                lk_q[d].delete();
                due_q[d].delete();
                chk($sformatf("d%0d rst out_valid", d), 128'(ov[d]), 128'd0);
                chk($sformatf("d%0d rst in_ready", d), 128'(ir[d]), 128'd1);
                chk($sformatf("d%0d rst busy", d), 128'(bsy[d]), 128'd0);
                chk($sformatf("d%0d rst dataout", d), dout[d], 128'd0);
`ifdef AES_LAST_KEY_OUT_EN
                chk($sformatf("d%0d rst last_key", d), lk[d], 128'd0);
`endif
            end else begin
                e_ov = (exp_q[d].size() != 0) && (cyc >= due_q[d][0]);
                e_ir = (exp_q[d].size() == 0) || (e_ov && ordy[d]);
                chk($sformatf("d%0d out_valid", d), 128'(ov[d]), 128'(e_ov));
                chk($sformatf("d%0d in_ready", d), 128'(ir[d]), 128'(e_ir));
                chk($sformatf("d%0d busy", d), 128'(bsy[d]), 128'((exp_q[d].size() != 0) && !e_ov));
                if (e_ov) begin
                    chk($sformatf("d%0d dataout", d), dout[d], exp_q[d][0]);
`ifdef AES_LAST_KEY_OUT_EN
                    chk($sformatf("d%0d last_key", d), lk[d], lk_q[d][0]);
`endif
                end
                if (e_ov && ordy[d]) begin
                    void'(exp_q[d].pop_front());
                    void'(lk_q[d].pop_front());
                    void'(due_q[d].pop_front());
                    n_dlv[d]++;
                    dlv_cyc[d] = cyc;
                    dlv_data[d] = dout[d];
                end
                if (iv[d] && e_ir) begin
                    aes_model(din[d], kin[d], nr_of[d], m_ct, m_lk);
                    exp_q[d].push_back(m_ct);
                    lk_q[d].push_back(m_lk);
                    due_q[d].push_back(cyc + nr_of[d] + 1);
                    n_acc[d]++;
                    acc_cyc[d] = cyc;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_block(input int d, input logic [127:0] pt, input logic [127:0] k);
        int seen = n_acc[d];
        int g = 0;
        iv[d] = 1'b1; din[d] = pt; kin[d] = k;
        while (n_acc[d] == seen && g < 100) begin tick(); g++; end
        iv[d] = 1'b0;
        chk($sformatf("d%0d accept", d), 128'(n_acc[d] - seen), 128'd1);
    endtask

    task automatic wait_dlv(input int d);
        int seen = n_dlv[d];
        int g = 0;
        while (n_dlv[d] == seen && g < 100) begin tick(); g++; end
        chk($sformatf("d%0d delivery", d), 128'(n_dlv[d] - seen), 128'd1);
    endtask

    task automatic rand_run(input int d, input int n);
        int a0 = n_acc[d];
        int d0 = n_dlv[d];
        int guard = 0;
        int seen;
        iv[d] = 1'b0;
        while (n_acc[d] - a0 < n && guard < n * 40) begin
            seen = n_acc[d];
            ordy[d] = ($urandom_range(0, 3) != 0);
            if (!iv[d] && $urandom_range(0, 3) != 0) begin
                iv[d] = 1'b1; din[d] = rand128(); kin[d] = rand128();
            end
            tick();
            guard++;
            if (n_acc[d] != seen) iv[d] = 1'b0;
        end
        iv[d] = 1'b0;
        ordy[d] = 1'b1;
        guard = 0;
        while (n_dlv[d] - d0 < n_acc[d] - a0 && guard < 100) begin tick(); guard++; end
        chk($sformatf("d%0d random accepted", d), 128'(n_acc[d] - a0), 128'(n));
        chk($sformatf("d%0d random delivered", d), 128'(n_dlv[d] - d0), 128'(n));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] ct, lkm, hold;
        int a0, d0, na, nd, g, acc2, dc1, dc2;
        logic [127:0] dd1, dd2;

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; iv[d] = 1'b0; ordy[d] = 1'b0; din[d] = '0; kin[d] = '0;
        end
        build_sbox();

        aes_model(APPB_PT, APPB_KEY, 10, ct, lkm);
        chk("model appB ct", ct, APPB_CT);
        aes_model(C1_PT, C1_KEY, 10, ct, lkm);
        chk("model C1 ct", ct, C1_CT);
        chk("model C1 last key", lkm, C1_LK);

        repeat (3) tick();
        rst[0] = 1'b0; rst[1] = 1'b0;
        tick();

        // App. B with immediate sink: latency and result
        ordy[0] = 1'b1;
        send_block(0, APPB_PT, APPB_KEY);
        wait_dlv(0);
        chk("appB latency", 128'(dlv_cyc[0] - acc_cyc[0] - 1), 128'd10);
        chk("appB dataout", dlv_data[0], APPB_CT);

        // C.1 with five cycles of backpressure
        ordy[0] = 1'b0;
        send_block(0, C1_PT, C1_KEY);
        g = 0;
        while (!ov[0] && g < 100) begin tick(); g++; end
        chk("bp out_valid", 128'(ov[0]), 128'd1);
        chk("C1 dataout", dout[0], C1_CT);
`ifdef AES_LAST_KEY_OUT_EN
        chk("C1 last_key", lk[0], C1_LK);
`endif
        hold = dout[0];
        d0 = n_dlv[0];
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp hold valid", 128'(ov[0]), 128'd1);
            chk("bp hold data", dout[0], hold);
            chk("bp in_ready", 128'(ir[0]), 128'd0);
        end
        ordy[0] = 1'b1;
        tick();
        chk("bp released", 128'(ov[0]), 128'd0);
        repeat (3) tick();
        chk("bp single transfer", 128'(n_dlv[0] - d0), 128'd1);

        // Back-to-back: App. B then C.1 with valid and ready held high
        a0 = n_acc[0]; d0 = n_dlv[0]; g = 0;
        acc2 = -1; dc1 = -1; dc2 = -1; dd1 = '0; dd2 = '0;
        iv[0] = 1'b1; din[0] = APPB_PT; kin[0] = APPB_KEY;
        while (n_dlv[0] - d0 < 2 && g < 80) begin
            na = n_acc[0]; nd = n_dlv[0];
            tick(); g++;
            if (n_acc[0] != na) begin
                if (n_acc[0] - a0 == 1) begin
                    din[0] = C1_PT; kin[0] = C1_KEY;
                end else begin
                    acc2 = acc_cyc[0]; iv[0] = 1'b0;
                end
            end
            if (n_dlv[0] != nd) begin
                if (n_dlv[0] - d0 == 1) begin dc1 = dlv_cyc[0]; dd1 = dlv_data[0]; end
                else begin dc2 = dlv_cyc[0]; dd2 = dlv_data[0]; end
            end
        end
        iv[0] = 1'b0;
        chk("b2b deliveries", 128'(n_dlv[0] - d0), 128'd2);
        chk("b2b accept on delivery", 128'(acc2), 128'(dc1));
        chk("b2b spacing", 128'(dc2 - dc1), 128'd11);
        chk("b2b first ct", dd1, APPB_CT);
        chk("b2b second ct", dd2, C1_CT);

        // Reset during round 4
        send_block(0, APPB_PT, APPB_KEY);
        repeat (3) tick();
        chk("pre-reset busy", 128'(bsy[0]), 128'd1);
        rst[0] = 1'b1;
        #1;
        chk("async rst out_valid", 128'(ov[0]), 128'd0);
        chk("async rst dataout", dout[0], 128'd0);
        chk("async rst in_ready", 128'(ir[0]), 128'd1);
        tick();
        rst[0] = 1'b0;
        tick();
        send_block(0, APPB_PT, APPB_KEY);
        wait_dlv(0);
        chk("post-reset appB", dlv_data[0], APPB_CT);

        // Randomised traffic with random backpressure
        rand_run(0, 25);
        rand_run(1, 1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes_iter_cipher.md
# aes_iter_cipher

Iterative, handshaked AES-128 encryption core, parametrised in round count. It supersedes the single-round cipher wrapper. Each block is processed over NR cycles through one shared round datapath with on-the-fly key expansion. It sits between a block-source FIFO and a ciphertext sink, and uses valid/ready on both sides.

## Interface
- NR, default 10: number of AES rounds executed, legal range 1..10. The final round always omits MixColumns.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  datain/key are valid.
- in_ready  output  1  core can accept a block this cycle.
- datain  input  128  plaintext, byte 0 = bits [127:120], column-major per FIPS-197.
- key  input  128  cipher key, same byte order.
- out_valid  output  1  dataout holds a finished ciphertext.
- out_ready  input  1  sink accepts dataout.
- dataout  output  128  ciphertext.
- busy  output  1  high while rounds are in progress.

## Operation
- FSM states:
  - IDLE, reset state.
  - RUN.
  - DONE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - state reg <= datain^key;
  - round-key reg <= key;
  - rnd <= 1;
  - go to RUN.
- RUN: each cycle:
  - next round key = KeyExpand(round-key reg, rcon[rnd]), with rcon = 01,02,04,08,10,20,40,80,1b,36;
  - state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), next key);
  - MixColumns is bypassed when rnd==NR;
  - round-key reg <= next key;
  - rnd increments.
  - After the rnd==NR update, go to DONE.
- DONE: out_valid=1 and dataout=state reg. These are held stable until out_ready.
  - out_ready alone: go to IDLE.
  - in_ready = IDLE | (DONE & out_ready), a combinational path from out_ready.
  - out_ready & in_valid in DONE: the new block is loaded exactly as from IDLE, and the FSM goes directly to RUN. No bubble.
- in_valid in RUN is ignored, and the inputs are not sampled.
- busy = (state==RUN).
- rnd is 4 bits. It never exceeds NR and never wraps.

## Timing
- Reset values:
  - in_ready=1;
  - out_valid=0;
  - busy=0;
  - dataout=0;
  - rnd=0;
  - round-key reg=0.
- Reset mid-RUN or mid-DONE aborts the block immediately. The partial result is never presented.
- Latency: acceptance edge E0, round updates on E1..ENR, out_valid high in the cycle after ENR. That is NR cycles after acceptance.
- Throughput with out_ready tied high: one block per NR+1 cycles.
- Backpressure: out_valid, dataout and in_ready=0 hold indefinitely while out_ready=0.
- All registers update only on clk rising edge, except for asynchronous rst.

## Configuration
- AES_LAST_KEY_OUT_EN:
  - Defined: adds output last_key[127:0], which is the final (round-NR) round key. It is valid with out_valid, held alongside dataout, reset to 0. It is used to seed a decryption key schedule.
  - Undefined: the port is absent. The round-key register is still required internally.

## Structure
- Shared package aes_pkg holds:
  - the S-box function (sbox lookup);
  - the rcon constant array;
  - xtime/MixColumns column function;
  - the FSM state enum;
  - the block/key width constant (128).
- One sub-module, aes_key_step: combinational single-step AES-128 key expansion (RotWord, SubWord, rcon XOR, word chaining).
- The data-round logic stays in the top module.

## Test plan
- FIPS-197 App. B, NR=10: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> dataout 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after acceptance.
- FIPS-197 C.1, NR=10: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a. With AES_LAST_KEY_OUT_EN, last_key = 13111d7fe3944a17f307a78b4d2b30c5.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> dataout unchanged, in_ready=0 throughout, a single transfer on out_ready=1.
- Back-to-back: in_valid and out_ready held high, App. B then C.1 vectors -> second block accepted on the same edge the first is delivered, out_valid pulses spaced 11 cycles apart, both results correct.
- Reset mid-operation: assert rst at round 4 -> out_valid=0, dataout=0, in_ready=1 immediately. A following App. B block produces the correct ciphertext.
- NR=1 build: compare random 1000 blocks against a software model (AddRoundKey, SubBytes, ShiftRows, AddRoundKey with round-1 key; no MixColumns) -> exact match, latency 1 cycle.
